// File: rtl/iterative_shift_unit_if.sv
// iterative_shift_unit_if: request/result bundle for the multi-cycle shift unit.
`default_nettype none

interface iterative_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   output1;

    modport master (
        output start, mode, a, b,
        input  busy, done, output1
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, output1
    );
endinterface

`default_nettype wire

// File: rtl/iterative_shift_unit.sv
// iterative_shift_unit: SLL/SRL/SRA/ROR, up to STEP positions per clock,
// start/busy/done handshake, 2*WIDTH result with fill word in the upper half.
`default_nettype none

module iterative_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  wire logic              clock_i,
    input  wire logic              reset_i,
    iterative_shift_unit_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    logic [1:0]           state_q,  state_d;
    logic [WIDTH-1:0]     opnd_q,   opnd_d;
    logic [SHAMT_W-1:0]   rem_q,    rem_d;
    logic [1:0]           mode_q,   mode_d;
    logic                 sign_q,   sign_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [SHAMT_W-1:0]   amt;
    logic [SHAMT_W-1:0]   step_amt;
    logic [WIDTH-1:0]     shifted;
    logic [2*WIDTH-1:0]   wide;
    logic [WIDTH-1:0]     fill_in;
    logic [WIDTH-1:0]     fill_q;
    logic                 unused_b;

    assign amt      = bus.b[SHAMT_W-1:0];
    assign unused_b = ^bus.b[WIDTH-1:SHAMT_W];
    assign step_amt = (rem_q > STEP_K) ? STEP_K : rem_q;

    // Fill depends only on the operand sign at accept time, never on the
    // partially shifted value.
    assign fill_in = {WIDTH{(bus.mode == MODE_SRA) && bus.a[WIDTH-1]}};
    assign fill_q  = {WIDTH{(mode_q == MODE_SRA) && sign_q}};

    always_comb begin
        wide    = '0;
        shifted = opnd_q;
        case (mode_q)
            MODE_SLL: shifted = opnd_q << step_amt;
            MODE_SRL: shifted = opnd_q >> step_amt;
            MODE_SRA: begin
                wide    = {{WIDTH{sign_q}}, opnd_q} >> step_amt;
                shifted = wide[WIDTH-1:0];
            end
            MODE_ROR: begin
                wide    = {opnd_q, opnd_q} >> step_amt;
                shifted = wide[WIDTH-1:0];
            end
            default: shifted = opnd_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    opnd_d = bus.a;
                    mode_d = bus.mode;
                    sign_d = bus.a[WIDTH-1];
                    rem_d  = amt;
                    if (amt != '0) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d  = S_DONE;
                        result_d = {fill_in, bus.a};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                opnd_d = shifted;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    state_d  = S_DONE;
                    result_d = {fill_q, shifted};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            opnd_q   <= '0;
            rem_q    <= '0;
            mode_q   <= MODE_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign bus.busy    = (state_q == S_SHIFT);
    assign bus.done    = (state_q == S_DONE);
    assign bus.output1 = result_q;

endmodule

`default_nettype wire
